// File: rtl/prmcu_uart_pkg.sv
// rtl/prmcu_uart_pkg.sv - shared types, constants and config helpers for the PRMCU UART
package prmcu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;
  localparam int UART_MIN_DIV       = 4;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAME   = 1;
  localparam int ERR_OVERRUN = 2;

  // Out-of-range data-bit counts are pulled into the supported 5..9 window.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
    if (n < 4'(UART_MIN_DATA_BITS)) return 4'(UART_MIN_DATA_BITS);
    if (n > 4'(UART_MAX_DATA_BITS)) return 4'(UART_MAX_DATA_BITS);
    return n;
  endfunction

  // 0 behaves as one stop bit, 3 as two.
  function automatic logic [1:0] clamp_stop_bits(input logic [1:0] n);
    return (n >= 2'd2) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/prmcu_uart_sync.sv
// rtl/prmcu_uart_sync.sv - flop-chain synchroniser for an asynchronous input, resets to 1
module prmcu_uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input one stage further down the chain each clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Chain registers; idle-high reset so a serial line does not look like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= sync_d;
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/prmcu_uart_receiver.sv
// rtl/prmcu_uart_receiver.sv - UART RX: mid-bit sampling deserialiser with valid/ready output register
module prmcu_uart_receiver
  import prmcu_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8,
  parameter int DATA_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_en,
  input  logic              rx_en,
  input  logic              n_parity_bits_i,
  input  logic [1:0]        n_stop_bits_i,
  input  logic [3:0]        n_data_bits_i,
  input  logic [DIV_W-1:0]  internal_clk_divider_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic [2:0]        out_err_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i
);

  logic rx_s;
  logic active;

  rx_state_t          state_q, state_d;
  logic [DIV_W:0]     cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               done_q, done_d;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         ndata_q, ndata_d;
  logic [1:0]         nstop_q, nstop_d;
  logic               par_en_q, par_en_d;

  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [2:0]         err_q, err_d;
  logic               vld_q, vld_d;

  logic [DIV_W:0]     half_cnt;
  logic [DIV_W:0]     last_cnt;
  logic               sample;

  prmcu_uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (rx_s)
  );

  assign active   = uart_en & rx_en;
  assign half_cnt = (DIV_W+1)'(div_q) >> 1;
  assign last_cnt = (DIV_W+1)'(div_q) - (DIV_W+1)'(1);
  assign sample   = (cnt_q == last_cnt);

  // Receive FSM: start detection, config latch, bit timing and per-frame error collection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    done_d    = 1'b0;
    div_d     = div_q;
    ndata_d   = ndata_q;
    nstop_d   = nstop_q;
    par_en_d  = par_en_q;

    if (!active) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          bit_d = '0;
          if (!rx_s) begin
            state_d   = START;
            shift_d   = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            div_d     = (internal_clk_divider_i < DIV_W'(UART_MIN_DIV)) ?
                        DIV_W'(UART_MIN_DIV) : internal_clk_divider_i;
            ndata_d   = clamp_data_bits(n_data_bits_i);
            nstop_d   = clamp_stop_bits(n_stop_bits_i);
            par_en_d  = n_parity_bits_i;
          end
        end
        START: begin
          if (cnt_q == half_cnt) begin
            cnt_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (sample) begin
            cnt_d = '0;
            for (int i = 0; i < DATA_W; i++) begin
              if (bit_q == 4'(i)) shift_d[i] = rx_s;
            end
            if (bit_q == ndata_q - 4'd1) begin
              bit_d   = '0;
              state_d = par_en_q ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (sample) begin
            cnt_d     = '0;
            par_err_d = (rx_s != ^shift_q);
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (sample) begin
            cnt_d = '0;
            if (!rx_s) frm_err_d = 1'b1;
            if (bit_q == {2'b00, nstop_q - 2'd1}) begin
              bit_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-deep output register: load on completion, flag overrun when the held word is still pending.
  always_comb begin
    dat_d = dat_q;
    err_d = err_q;
    vld_d = vld_q;
    if (done_q) begin
      if (!vld_q || out_rdy_i) begin
        dat_d              = shift_q;
        err_d              = 3'b000;
        err_d[ERR_FRAME]   = frm_err_q;
        err_d[ERR_PARITY]  = par_err_q;
        vld_d              = 1'b1;
      end else begin
        err_d[ERR_OVERRUN] = 1'b1;
      end
    end else if (vld_q && out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= DIV_W'(UART_MIN_DIV);
      ndata_q   <= 4'(UART_MIN_DATA_BITS);
      nstop_q   <= 2'd1;
      par_en_q  <= 1'b0;
      dat_q     <= '0;
      err_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      done_q    <= done_d;
      div_q     <= div_d;
      ndata_q   <= ndata_d;
      nstop_q   <= nstop_d;
      par_en_q  <= par_en_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
    end
  end

  assign out_dat_o = dat_q;
  assign out_err_o = err_q;
  assign out_vld_o = vld_q;

endmodule

// File: tb/tb_prmcu_uart_receiver.sv
// tb/tb_prmcu_uart_receiver.sv - self-checking bench for prmcu_uart_receiver
module tb_prmcu_uart_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int DIV_W       = 8;
  localparam int DATA_W      = 9;
  localparam int WAIT_LIMIT  = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              uart_en = 1'b1;
  logic              rx_en = 1'b1;
  logic              n_parity_bits_i = 1'b0;
  logic [1:0]        n_stop_bits_i = 2'd1;
  logic [3:0]        n_data_bits_i = 4'd8;
  logic [DIV_W-1:0]  internal_clk_divider_i = 8'd87;
  logic              rx_i = 1'b1;
  logic [DATA_W-1:0] out_dat_o;
  logic [2:0]        out_err_o;
  logic              out_vld_o;
  logic              out_rdy_i = 1'b1;

  int checks = 0;
  int failures = 0;
  int vld_cycles = 0;
  logic [11:0] got_q[$];

  prmcu_uart_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .DIV_W(DIV_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .uart_en                (uart_en),
    .rx_en                  (rx_en),
    .n_parity_bits_i        (n_parity_bits_i),
    .n_stop_bits_i          (n_stop_bits_i),
    .n_data_bits_i          (n_data_bits_i),
    .internal_clk_divider_i (internal_clk_divider_i),
    .rx_i                   (rx_i),
    .out_dat_o              (out_dat_o),
    .out_err_o              (out_err_o),
    .out_vld_o              (out_vld_o),
    .out_rdy_i              (out_rdy_i)
  );

  always #5 clk = ~clk;

  // Capture every accepted word as {err, dat}; count cycles with valid high.
  always @(negedge clk) begin
    if (rst) begin
      if (out_vld_o) vld_cycles++;
      if (out_vld_o && out_rdy_i) got_q.push_back({out_err_o, out_dat_o});
    end
  end

  // Frame-level reference: effective data-bit count, masked data, parity and framing verdicts.
  function automatic int eff_bits(input int raw);
    if (raw < 5) return 5;
    if (raw > 9) return 9;
    return raw;
  endfunction

  function automatic int eff_stops(input int raw);
    return (raw >= 2) ? 2 : 1;
  endfunction

  function automatic logic [11:0] model(input logic [8:0] data, input int nbits, input bit par_en,
                                        input logic par_bit, input logic stop_val);
    logic [8:0] m;
    int ones;
    logic pe, fe;
    m = data & 9'((1 << nbits) - 1);
    ones = $countones(m);
    pe = par_en && (par_bit != logic'(ones % 2));
    fe = (stop_val == 1'b0);
    return {1'b0, fe, pe, m};
  endfunction

  task automatic drive_bit(input logic b, input int div);
    rx_i = b;
    repeat (div) @(posedge clk);
    #1;
  endtask

  // Drives raw config inputs then a whole frame; stop_val is used for every stop bit.
  task automatic send_frame(input logic [8:0] data, input int raw_bits, input bit par_en,
                            input logic par_bit, input int raw_stops, input logic stop_val,
                            input int div);
    int nb, ns;
    nb = eff_bits(raw_bits);
    ns = eff_stops(raw_stops);
    n_data_bits_i          = 4'(raw_bits);
    n_parity_bits_i        = par_en;
    n_stop_bits_i          = 2'(raw_stops);
    internal_clk_divider_i = DIV_W'(div);
    drive_bit(1'b0, div);
    for (int i = 0; i < nb; i++) drive_bit(data[i], div);
    if (par_en) drive_bit(par_bit, div);
    for (int s = 0; s < ns; s++) drive_bit(stop_val, div);
    rx_i = 1'b1;
  endtask

  task automatic wait_word(output logic [11:0] w, output bit ok);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() > 0) begin
      w  = got_q.pop_front();
      ok = 1'b1;
    end else begin
      w  = 'x;
      ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_dat_o !== 9'h000) begin
      failures++;
      $display("FAIL reset_dat got=%h exp=000", out_dat_o);
    end
    checks++;
    if (out_err_o !== 3'b000) begin
      failures++;
      $display("FAIL reset_err got=%b exp=000", out_err_o);
    end
    checks++;
    if (out_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_vld got=%b exp=0", out_vld_o);
    end
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_parity;
    logic [11:0] w, exp;
    bit ok;
    vld_cycles = 0;
    exp = model(9'h0A5, 8, 1'b1, 1'b0, 1'b1);
    send_frame(9'h0A5, 8, 1'b1, 1'b0, 2, 1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp || w !== 12'h0A5) begin
      failures++;
      $display("FAIL parity_ok got=%h exp=%h ok=%0d", w, exp, ok);
    end
    checks++;
    if (vld_cycles !== 1) begin
      failures++;
      $display("FAIL vld_one_cycle got=%0d exp=1", vld_cycles);
    end
    exp = model(9'h03C, 8, 1'b1, 1'b1, 1'b1);
    send_frame(9'h03C, 8, 1'b1, 1'b1, 2, 1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp || w !== 12'h23C) begin
      failures++;
      $display("FAIL parity_err got=%h exp=%h ok=%0d", w, exp, ok);
    end
  endtask

  task automatic test_frame_err;
    logic [11:0] w, exp;
    bit ok;
    exp = model(9'h02B, 6, 1'b0, 1'b0, 1'b0);
    send_frame(9'h02B, 6, 1'b0, 1'b0, 1, 1'b0, 87);
    drive_bit(1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp || w !== 12'h42B) begin
      failures++;
      $display("FAIL frame_err got=%h exp=%h ok=%0d", w, exp, ok);
    end
    exp = model(9'h015, 6, 1'b0, 1'b0, 1'b1);
    send_frame(9'h015, 6, 1'b0, 1'b0, 1, 1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp) begin
      failures++;
      $display("FAIL after_frame_err got=%h exp=%h ok=%0d", w, exp, ok);
    end
  endtask

  task automatic test_glitch;
    logic [11:0] w, exp;
    bit ok;
    vld_cycles = 0;
    internal_clk_divider_i = 8'd87;
    rx_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (3 * 87) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || vld_cycles != 0) begin
      failures++;
      $display("FAIL glitch_reject got_words=%0d vld_cycles=%0d exp=0", got_q.size(), vld_cycles);
    end
    exp = model(9'h011, 8, 1'b0, 1'b0, 1'b1);
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp) begin
      failures++;
      $display("FAIL after_glitch got=%h exp=%h ok=%0d", w, exp, ok);
    end
  endtask

  task automatic test_overrun;
    logic [11:0] w;
    bit ok;
    out_rdy_i = 1'b0;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 87);
    drive_bit(1'b1, 87);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 87);
    drive_bit(1'b1, 87);
    checks++;
    if (out_vld_o !== 1'b1 || out_dat_o !== 9'h011 || out_err_o !== 3'b100) begin
      failures++;
      $display("FAIL overrun_hold got vld=%b dat=%h err=%b exp vld=1 dat=011 err=100",
               out_vld_o, out_dat_o, out_err_o);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL overrun_no_transfer got_words=%0d exp=0", got_q.size());
    end
    out_rdy_i = 1'b1;
    wait_word(w, ok);
    checks++;
    if (!ok || w !== 12'h811) begin
      failures++;
      $display("FAIL overrun_transfer got=%h exp=811 ok=%0d", w, ok);
    end
    @(negedge clk);
    checks++;
    if (out_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_vld_clear got=%b exp=0", out_vld_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe;
    logic [11:0] w, exp;
    bit ok;
    exp = model(9'h1FF, 9, 1'b0, 1'b0, 1'b1);
    send_frame(9'h1FF, 9, 1'b0, 1'b0, 1, 1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp || w !== 12'h1FF) begin
      failures++;
      $display("FAIL word_9bit got=%h exp=%h ok=%0d", w, exp, ok);
    end
    out_rdy_i = 1'b0;
    drive_bit(1'b0, 87);
    drive_bit(1'b1, 87);
    drive_bit(1'b0, 87);
    drive_bit(1'b1, 40);
    rst = 1'b0;
    #1;
    checks++;
    if (out_dat_o !== 9'h000 || out_err_o !== 3'b000 || out_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset got dat=%h err=%b vld=%b exp 000/000/0",
               out_dat_o, out_err_o, out_vld_o);
    end
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    out_rdy_i = 1'b1;
    drive_bit(1'b1, 2 * 87);
    exp = model(9'h0C3, 9, 1'b0, 1'b0, 1'b1);
    send_frame(9'h0C3, 9, 1'b0, 1'b0, 1, 1'b1, 87);
    drive_bit(1'b1, 87);
    wait_word(w, ok);
    checks++;
    if (!ok || w !== exp) begin
      failures++;
      $display("FAIL after_reset got=%h exp=%h ok=%0d", w, exp, ok);
    end
  endtask

  task automatic test_random;
    logic [11:0] w, exp;
    logic [8:0] data;
    int raw_bits, raw_stops, div, nb;
    bit par_en, ok;
    logic par_bit, stop_val;
    out_rdy_i = 1'b1;
    for (int f = 0; f < 20; f++) begin
      data      = 9'($urandom);
      raw_bits  = int'($urandom_range(0, 15));
      raw_stops = int'($urandom_range(0, 3));
      div       = int'($urandom_range(8, 40));
      par_en    = bit'($urandom_range(0, 1));
      nb        = eff_bits(raw_bits);
      par_bit   = logic'(($countones(data & 9'((1 << nb) - 1)) % 2) != 0);
      if ($urandom_range(0, 3) == 0) par_bit = ~par_bit;
      stop_val  = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      exp = model(data, nb, par_en, par_bit, stop_val);
      send_frame(data, raw_bits, par_en, par_bit, raw_stops, stop_val, div);
      drive_bit(1'b1, 2 * div);
      wait_word(w, ok);
      checks++;
      if (!ok || w !== exp) begin
        failures++;
        $display("FAIL random_frame%0d got=%h exp=%h ok=%0d bits=%0d par=%0d stops=%0d div=%0d",
                 f, w, exp, ok, raw_bits, par_en, raw_stops, div);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
